detector_sched: RTL and testbench

Round-robin scheduler that shares one serial "0110" sequence detector between two word-level requesters. Each accepted W-bit word is serialized MSB-first into the detector, one bit per clock. Matches are counted per word, and a tagged result (requester id, match count) is returned over a valid/ready handshake. The block sits in front of the detector FSM and owns the detector's reset and bit sequencing, so words from different requesters never share detector state.

---
 rtl/detector_sched.sv | 132 +++++++++++++
 tb/tb_detector_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_sched.sv
// Round-robin scheduler sharing one serial "0110" detector between two word requesters.
// Optional macro DET_OVERLAP_EN: when defined, overlapping "0110" matches are counted.
module detector_sched #(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  input  logic [W-1:0]             req_word0,
  input  logic [W-1:0]             req_word1,
  output logic [1:0]               req_ready,
  output logic                     res_valid,
  output logic                     res_id,
  output logic [$clog2(W+1)-1:0]   res_count,
  input  logic                     res_ready,
  output logic                     det_i,
  output logic                     det_o
);

  localparam int CNT_W = $clog2(W+1);
  localparam int IDX_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

`ifdef DET_OVERLAP_EN
  localparam det_t DET_AFTER_HIT = S1;
`else
  localparam det_t DET_AFTER_HIT = S0;
`endif

  state_t             state, state_nxt;
  det_t               det_st, det_nxt;
  logic [W-1:0]       word_q;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               id_q;
  logic               last_grant;
  logic               gid;
  logic [1:0]         grant;
  logic               accept;
  logic               bit_in;
  logic               hit;
  logic               last_bit;

  // Arbitration: a tie goes to the requester not granted last
  always_comb begin
    gid   = 1'b0;
    grant = 2'b00;
    case (req_valid)
      2'b01:   gid = 1'b0;
      2'b10:   gid = 1'b1;
      2'b11:   gid = ~last_grant;
      default: gid = 1'b0;
    endcase
    if (|req_valid) grant[gid] = 1'b1;
  end

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? grant : 2'b00;

  // The word register shifts left so its MSB is always the bit being presented
  assign bit_in    = (state == SHIFT) ? word_q[W-1] : 1'b0;
  assign hit       = (state == SHIFT) && (det_st == S3) && !bit_in;
  assign last_bit  = (idx == IDX_W'(W-1));

  assign det_i     = bit_in;
  assign det_o     = hit;
  assign res_valid = (state == DONE);
  assign res_id    = id_q;
  assign res_count = cnt;

  always_comb begin
    det_nxt = det_st;
    case (det_st)
      S0: det_nxt = bit_in ? S0 : S1;
      S1: det_nxt = bit_in ? S2 : S1;
      S2: det_nxt = bit_in ? S3 : S1;
      S3: det_nxt = bit_in ? S0 : DET_AFTER_HIT;
      default: det_nxt = S0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      cnt        <= '0;
      det_st     <= S0;
      idx        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            id_q       <= gid;
            last_grant <= gid;
            cnt        <= '0;
            det_st     <= S0;
            idx        <= '0;
          end
        end
        SHIFT: begin
          det_st <= det_nxt;
          idx    <= idx + IDX_W'(1);
          if (hit) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Word data carries no reset; it is only observed while SHIFT is active
  always_ff @(posedge clk) begin
    if (accept)
      word_q <= gid ? req_word1 : req_word0;
    else if (state == SHIFT)
      word_q <= {word_q[W-2:0], 1'b0};
  end

endmodule

// File: tb/tb_detector_sched.sv
// Self-checking bench for detector_sched: cycle-level reference model plus directed transactions.
module tb_detector_sched;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W+1);
`ifdef DET_OVERLAP_EN
  localparam int EXP_6C = 2;
`else
  localparam int EXP_6C = 1;
`endif

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [W-1:0]     req_word0;
  logic [W-1:0]     req_word1;
  logic [1:0]       req_ready;
  logic             res_valid;
  logic             res_id;
  logic [CNT_W-1:0] res_count;
  logic             res_ready;
  logic             det_i;
  logic             det_o;

  int checks;
  int errors;
  int first_hit;

  detector_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_word0(req_word0), .req_word1(req_word1),
    .req_ready(req_ready),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count), .res_ready(res_ready),
    .det_i(det_i), .det_o(det_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Match-end positions in serial (MSB-first) order, found by scanning the bit string
  function automatic logic [W-1:0] hits_of(input logic [W-1:0] w);
    logic [W-1:0] h;
    logic [W-1:0] s;
    int i;
    h = '0;
    for (int k = 0; k < W; k++) s[k] = w[W-1-k];
    i = 0;
    while (i <= W-4) begin
      if (!s[i] && s[i+1] && s[i+2] && !s[i+3]) begin
        h[i+3] = 1'b1;
`ifdef DET_OVERLAP_EN
        i = i + 1;
`else
        i = i + 4;
`endif
      end else begin
        i = i + 1;
      end
    end
    return h;
  endfunction

  function automatic logic model_gid(input logic [1:0] v, input logic last);
    return (v == 2'b11) ? ~last : v[1];
  endfunction

  // Reference model: phase 0 idle, 1 serializing (mk = bit index), 2 result held
  int           mphase;
  int           mk;
  logic [W-1:0] mword;
  logic [W-1:0] mhits;
  logic         mid;
  logic         mlast;
  logic         armed;

  always @(posedge clk) begin
    if (rst) begin
      mphase <= 0;
      mlast  <= 1'b1;
      armed  <= 1'b1;
    end else if (armed) begin
      case (mphase)
        0: if (|req_valid) begin
          mid    <= model_gid(req_valid, mlast);
          mlast  <= model_gid(req_valid, mlast);
          mword  <= model_gid(req_valid, mlast) ? req_word1 : req_word0;
          mhits  <= hits_of(model_gid(req_valid, mlast) ? req_word1 : req_word0);
          mk     <= 0;
          mphase <= 1;
        end
        1: begin
          if (mk == W-1) mphase <= 2;
          mk <= mk + 1;
        end
        default: if (res_ready) mphase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic [1:0] exp_ready;
      exp_ready = 2'b00;
      if (mphase == 0 && |req_valid) exp_ready[model_gid(req_valid, mlast)] = 1'b1;
      chk("m_req_ready", req_ready, exp_ready);
      chk("m_res_valid", res_valid, mphase == 2);
      if (mphase == 2) begin
        chk("m_res_id", res_id, mid);
        chk("m_res_count", res_count, $countones(mhits));
      end
      chk("m_det_i", det_i, (mphase == 1) ? mword[W-1-mk] : 1'b0);
      chk("m_det_o", det_o, (mphase == 1) ? mhits[mk] : 1'b0);
    end
  end

  task automatic wait_ready(output logic [1:0] g);
    bit ok;
    ok = 0;
    g  = 2'b00;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        ok = 1;
        g  = req_ready;
      end
    end
    if (!ok) chk("timeout_ready", 0, 1);
  endtask

  task automatic wait_res(output int n, output int pulses);
    bit ok;
    ok = 0;
    n = 0;
    pulses = 0;
    first_hit = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (res_valid) ok = 1;
      else if (det_o) begin
        pulses++;
        if (first_hit < 0) first_hit = n - 1;
      end
    end
    if (!ok) chk("timeout_result", 0, 1);
  endtask

  task automatic handshake();
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_after_hs", res_valid, 1'b0);
  endtask

  task automatic do_word(input logic [1:0] v, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input int exp_id, input int exp_cnt, input string name);
    logic [1:0] g;
    int n, pulses;
    @(posedge clk); #1;
    req_valid = v;
    req_word0 = w0;
    req_word1 = w1;
    wait_ready(g);
    chk({name, "_grant"}, g, 2'b01 << exp_id);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_res(n, pulses);
    chk({name, "_latency"}, n - 1, W);
    chk({name, "_id"}, res_id, exp_id);
    chk({name, "_count"}, res_count, exp_cnt);
    chk({name, "_pulses"}, pulses, exp_cnt);
    handshake();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_res_valid"}, res_valid, 1'b0);
    chk({name, "_req_ready"}, req_ready, 2'b00);
    chk({name, "_res_id"}, res_id, 1'b0);
    chk({name, "_res_count"}, res_count, 0);
    chk({name, "_det_i"}, det_i, 1'b0);
    chk({name, "_det_o"}, det_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    logic       hid;
    logic [CNT_W-1:0] hcnt;
    int ids[$];
    int cnts[$];
    int grants[$];
    int n, pulses;

    checks = 0; errors = 0; first_hit = -1;
    clk = 0; rst = 1; armed = 0; mphase = 0; mk = 0; mlast = 1;
    req_valid = 2'b00; req_word0 = '0; req_word1 = '0; res_ready = 1'b0;

    // Hand-computed pins on the reference scan
    chk("model_66", $countones(hits_of(8'h66)), 2);
    chk("model_6C", $countones(hits_of(8'b0110_1100)), EXP_6C);
    chk("model_60_pos", hits_of(8'b0110_0000), 8'h08);
    chk("model_F6", $countones(hits_of(8'b1111_0110)), 1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    do_word(2'b01, 8'b0110_0000, 8'h00, 0, 1, "single");
    chk("single_hit_bit", first_hit, 3);
    do_word(2'b01, 8'b0110_1100, 8'h00, 0, EXP_6C, "overlap");
    do_word(2'b10, 8'h00, 8'h66, 1, 2, "req1");

    // Fresh reset so the first tie goes to requester 0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset2");

    @(posedge clk); #1;
    req_valid = 2'b11; req_word0 = 8'h00; req_word1 = 8'h66; res_ready = 1'b1;
    for (int i = 0; i < 200 && ids.size() < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) grants.push_back(int'(req_ready));
      if (res_valid) begin
        ids.push_back(int'(res_id));
        cnts.push_back(int'(res_count));
      end
    end
    @(posedge clk); #1 req_valid = 2'b00; res_ready = 1'b0;
    chk("alt_results", ids.size(), 4);
    for (int i = 0; i < 4 && i < ids.size(); i++) begin
      chk("alt_id", ids[i], i % 2);
      chk("alt_count", cnts[i], (i % 2) ? 2 : 0);
    end
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("alt_grant", grants[i], (i % 2) ? 2 : 1);

    // Result held in DONE with the consumer stalled and both requesters waiting
    @(posedge clk); #1;
    req_valid = 2'b11; req_word0 = 8'b0110_1100; req_word1 = 8'h66;
    wait_res(n, pulses);
    hid = res_id;
    hcnt = res_count;
    chk("hold_id", hid, 1'b0);
    chk("hold_count", hcnt, EXP_6C);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_id_stable", res_id, hid);
      chk("hold_count_stable", res_count, hcnt);
      chk("hold_req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bubble_res_valid", res_valid, 1'b0);
    chk("bubble_req_ready", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_res(n, pulses);
    chk("post_hold_latency", n - 1, W);
    chk("post_hold_id", res_id, 1'b1);
    chk("post_hold_count", res_count, 2);
    handshake();

    // Reset while serializing bit 4 drops the word and resets the pointer
    @(posedge clk); #1 req_valid = 2'b01; req_word0 = 8'h66;
    wait_ready(g);
    chk("rst_word_grant", g, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("dropped_no_result", res_valid, 1'b0);
    end
    do_word(2'b11, 8'b0110_0000, 8'h66, 0, 1, "after_rst");

    // Detector state must not carry from one word into the next
    do_word(2'b01, 8'b0000_1011, 8'h00, 0, 0, "tail011");
    do_word(2'b10, 8'h00, 8'b1111_0110, 1, 1, "carry_F6");
    do_word(2'b01, 8'b0000_1011, 8'h00, 0, 0, "tail011b");
    do_word(2'b01, 8'h00, 8'h00, 0, 0, "carry_00");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
